// File: rtl/cacheline_adaptor.sv
// Converts one 256-bit cache line fill/write-back into a four-beat 64-bit pmem burst.
// Optional stall watchdog enabled by defining CACHELINE_TIMEOUT_EN.
module cacheline_adaptor #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cacheline_read,
  input  logic         cacheline_write,
  input  logic [31:0]  cacheline_address,
  input  logic [255:0] cacheline_wdata,
  output logic [255:0] cacheline_rdata,
  output logic         cacheline_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [63:0]  pmem_wdata,
  input  logic [63:0]  pmem_rdata,
  input  logic         pmem_resp,
  output logic         timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [1:0]        beat;
  logic [26:0]       line_addr;
  logic [3:0][63:0]  wline;
  logic [2:0][63:0]  fill;
  logic [255:0]      rdata;

  logic take_read;
  logic take_write;
  logic in_burst;
  logic last_beat;
  logic timeout_hit;

  // Both requests high at once is illegal and simply ignored.
  assign take_read  = (state == IDLE) && cacheline_read && !cacheline_write;
  assign take_write = (state == IDLE) && cacheline_write && !cacheline_read;
  assign in_burst   = (state == RD) || (state == WR);
  assign last_beat  = in_burst && pmem_resp && (beat == 2'd3);

`ifdef CACHELINE_TIMEOUT_EN
  logic [15:0] stall;
  logic        timeout_flag;

  assign timeout_hit = in_burst && !pmem_resp && (stall == 16'(TIMEOUT_CYCLES - 1));

  // Stall counter sits at zero outside a burst, so entry to RD/WR starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall <= '0;
    end else if (!in_burst || pmem_resp) begin
      stall <= '0;
    end else begin
      stall <= stall + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_flag <= 1'b0;
    end else begin
      timeout_flag <= timeout_hit;
    end
  end

  assign timeout_err = timeout_flag;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (take_read) begin
          state_next = RD;
        end else if (take_write) begin
          state_next = WR;
        end
      end
      RD, WR: begin
        if (timeout_hit || last_beat) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Beat index: zero while idle, advances only on accepted beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat <= '0;
    end else if (!in_burst) begin
      beat <= '0;
    end else if (pmem_resp) begin
      beat <= beat + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_addr <= '0;
    end else if (take_read || take_write) begin
      line_addr <= cacheline_address[31:5];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wline <= '0;
    end else if (take_write) begin
      wline <= cacheline_wdata;
    end
  end

  // First three read beats are staged; the fourth completes the line directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill <= '0;
    end else if ((state == RD) && pmem_resp) begin
      for (int i = 0; i < 3; i++) begin
        if (beat == 2'(i)) begin
          fill[i] <= pmem_rdata;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if ((state == RD) && last_beat) begin
      rdata <= {pmem_rdata, fill[2], fill[1], fill[0]};
    end
  end

  assign cacheline_rdata = rdata;
  assign cacheline_resp  = (state == DONE);
  assign pmem_read       = (state == RD);
  assign pmem_write      = (state == WR);
  assign pmem_address    = {line_addr, 5'b0};
  assign pmem_wdata      = (state == WR) ? wline[beat] : '0;

endmodule
